// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the up/down counter read-side monitor.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    INIT,
    ACQ,
    LOCKED
  } state_e;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DN,
    STEP_BAD
  } step_e;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/step_classifier.sv
// Classifies one observed counter transition as hold, +1, -1 or illegal,
// and flags steps that cross the all-ones/zero boundary.
module step_classifier
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] data,
  output step_e            step,
  output logic             wrap
);

  logic [WIDTH-1:0] delta;

  always_comb begin
    delta = data - prev;
    step  = STEP_BAD;
    wrap  = 1'b0;
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == WIDTH'(1)) begin
      step = STEP_UP;
      wrap = (prev == '1);
    end else if (delta == '1) begin
      step = STEP_DN;
      wrap = (prev == '0);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Recovers direction, step and wrap events from an observed up/down count
// stream, locking onto a direction and counting illegal transitions.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic                 dir_o,
  output logic                 locked_o,
  output logic                 step_o,
  output logic                 wrap_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned RUN_W = 3;

  state_e               state;
  logic [WIDTH-1:0]     prev;
  logic [RUN_W-1:0]     run_cnt;
  step_e                cls;
  logic                 cls_wrap;
  logic                 step_up;
  logic [RUN_W-1:0]     run_next;
  logic [ERR_CNT_W-1:0] err_cnt_next;

  step_classifier #(
    .WIDTH(WIDTH)
  ) u_step_classifier (
    .prev(prev),
    .data(data_i),
    .step(cls),
    .wrap(cls_wrap)
  );

  // A step against the current direction restarts the run at one.
  always_comb begin
    step_up      = (cls == STEP_UP);
    run_next     = (step_up == dir_o) ? run_cnt + RUN_W'(1) : RUN_W'(1);
    err_cnt_next = (err_cnt_o == '1) ? err_cnt_o : err_cnt_o + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= INIT;
      prev      <= '0;
      run_cnt   <= '0;
      dir_o     <= 1'b0;
      locked_o  <= 1'b0;
      step_o    <= 1'b0;
      wrap_o    <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      step_o <= 1'b0;
      wrap_o <= 1'b0;
      err_o  <= 1'b0;
      if (en_i) begin
        prev <= data_i;
        unique case (state)
          INIT: begin
            state <= ACQ;
          end
          ACQ: begin
            unique case (cls)
              STEP_UP, STEP_DN: begin
                step_o  <= 1'b1;
                wrap_o  <= cls_wrap;
                dir_o   <= step_up;
                run_cnt <= run_next;
                if (run_next == RUN_W'(LOCK_CNT)) begin
                  state    <= LOCKED;
                  locked_o <= 1'b1;
                end
              end
              STEP_BAD: begin
                run_cnt   <= '0;
                err_o     <= 1'b1;
                err_cnt_o <= err_cnt_next;
              end
              default: ;
            endcase
          end
          LOCKED: begin
            unique case (cls)
              STEP_UP, STEP_DN: begin
                step_o <= 1'b1;
                wrap_o <= cls_wrap;
                dir_o  <= step_up;
              end
              STEP_BAD: begin
                state     <= ACQ;
                locked_o  <= 1'b0;
                run_cnt   <= '0;
                err_o     <= 1'b1;
                err_cnt_o <= err_cnt_next;
              end
              default: ;
            endcase
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Checker/decoder on the read side of the 4-bit up/down counter. Samples the counter's output value every enabled cycle and recovers what the counter was told to do: direction (`dir_o`, same encoding as the counter's `sel_i`), step events and wrap-around events. Flags any transition that an up/down-by-one counter cannot produce. Sits next to the counter in the datapath as a self-check and as a direction source for downstream logic.

## Interface
- `WIDTH`, 4: bit width of the observed count.
- `LOCK_CNT`, 2: number of consecutive same-direction steps needed to lock; legal range 1..7.
- `clk_i` input 1: clock; every sample and output update happens on the rising edge.
- `rst_ni` input 1: reset, **asynchronous, active-low**; the design has one clock.
- `en_i` input 1: when 1, `data_i` is sampled this cycle; when 0, state and outputs are held and pulses are 0.
- `data_i` input `WIDTH`: observed count value.
- `dir_o` output 1: recovered direction; 1 = up, 0 = down.
- `locked_o` output 1: direction confirmed by `LOCK_CNT` consistent steps.
- `step_o` output 1: one-cycle pulse on a legal ±1 step.
- `wrap_o` output 1: one-cycle pulse when a step wraps, either max→0 going up or 0→max going down.
- `err_o` output 1: one-cycle pulse on an illegal transition.
- `err_cnt_o` output 8: count of illegal transitions; saturates at 255.

## Operation
- Step classification, per sample, with `delta = data_i - prev` taken modulo 2^WIDTH:
  - `delta` = 0 → HOLD
  - `delta` = 1 → UP
  - `delta` = all-ones → DN
  - anything else → BAD
- `prev` is updated with `data_i` on every enabled sample, including BAD samples.
- **INIT** (reset state):
  - The first enabled sample loads `prev` and moves to ACQ.
  - No classification is done and no pulses are produced.
- **ACQ**:
  - HOLD: no change.
  - UP or DN in the same direction as `dir_o`: `run_cnt` increments and `step_o` pulses.
  - UP or DN in the opposite direction: `dir_o` takes the new direction, `run_cnt` = 1, and `step_o` pulses.
  - When `run_cnt` reaches `LOCK_CNT`, move to LOCKED and set `locked_o` = 1.
  - BAD: `run_cnt` = 0, `err_o` pulses, stay in ACQ.
- **LOCKED**:
  - UP or DN: `step_o` pulses. A reversal is legal and takes effect by updating `dir_o` only.
  - HOLD: no change.
  - BAD: `err_o` pulses, `locked_o` = 0, `run_cnt` = 0, move to ACQ.
- `wrap_o` pulses together with `step_o` whenever the step crosses the boundary: UP with `prev` = all-ones, or DN with `prev` = 0. This applies in ACQ and LOCKED.
- `err_cnt_o` increments on every `err_o` pulse and sticks at 255. Only reset clears it.
- Each sample produces exactly one of HOLD, step or error. `step_o` and `err_o` are never high together.

## Timing
- All outputs are registered. The effect of a sample on edge N is visible right after edge N, i.e. in the cycle following the sample.
- Reset values: state INIT, `prev` = 0, `run_cnt` = 0, `dir_o` = 0, `locked_o` = 0, `step_o` = 0, `wrap_o` = 0, `err_o` = 0, `err_cnt_o` = 0.
- Asserting `rst_ni` at any time, including mid-lock, clears everything immediately without waiting for a clock edge. The first sample after release only re-initialises `prev`.
- `en_i` low freezes everything. A gap in `en_i` is transparent: the next sample is compared against the last enabled sample.
- Lock latency from INIT: with a clean monotonic stream, `locked_o` rises after the (`LOCK_CNT`+1)th enabled sample.

## Structure
- Package `count_monitor_pkg` contains:
  - `state_e` enum {INIT, ACQ, LOCKED}
  - `step_e` enum {STEP_HOLD, STEP_UP, STEP_DN, STEP_BAD}
  - `ERR_CNT_W` = 8
- Sub-module `step_classifier` is purely combinational. It takes `prev` and `data_i` and returns a `step_e` value plus a wrap flag.
- The top level holds the FSM, the `prev` and `run_cnt` registers, the output registers and the saturating error counter.

## Test plan
All scenarios use `WIDTH` = 4 and `LOCK_CNT` = 2.
- **Reset then lock up:** samples 3, 4, 5 → `step_o` pulses after 4 and after 5; `locked_o` = 1 and `dir_o` = 1 after 5.
- **Up wrap:** locked up, samples 14, 15, 0, 1 → `wrap_o` pulses only after 0; `err_o` = 0 throughout.
- **Down lock and wrap, then reversal:**
  - Samples 2, 1, 0, 15 → `dir_o` = 0 and `locked_o` = 1 after 0; `wrap_o` pulses after 15.
  - Then sample 0 → `dir_o` = 1, `locked_o` stays 1.
- **Illegal jump:** locked up at 6, then sample 9 → `err_o` pulses, `locked_o` = 0, `err_cnt_o` = 1.
  - Then 10, 11 → relock after 11.
- **Hold and enable gap:** locked at 7, samples 7, 7, then `en_i` = 0 for 5 cycles with `data_i` = 12, then enabled sample 8 → no pulses during hold or gap; `step_o` pulses after 8.
- **Asynchronous reset mid-lock, plus saturation:**
  - Assert `rst_ni` low between clock edges while locked → all outputs 0 immediately.
  - Separately, drive 300 illegal jumps → `err_cnt_o` holds at 255.
